// File: rtl/wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO bridge: register word offsets,
// handshake FSM state encoding and register reset values.
package wb_gpio_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } wb_state_t;

  // Word offsets, i.e. wbs_adr_i[7:2]
  localparam logic [5:0] OFF_DOUT     = 6'h00;
  localparam logic [5:0] OFF_OEB      = 6'h01;
  localparam logic [5:0] OFF_DIN      = 6'h02;
  localparam logic [5:0] OFF_IRQ_EN   = 6'h03;
  localparam logic [5:0] OFF_IRQ_STAT = 6'h04;
  localparam logic [5:0] OFF_EDGE     = 6'h05;

  localparam logic [31:0] DOUT_RST     = 32'h0000_0000;
  localparam logic [31:0] OEB_RST      = 32'hFFFF_FFFF;
  localparam logic [31:0] IRQ_EN_RST   = 32'h0000_0000;
  localparam logic [31:0] IRQ_STAT_RST = 32'h0000_0000;
  localparam logic [31:0] EDGE_RST     = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_gpio_bridge_if.sv
// Wishbone slave bus bundle between the management SoC and the GPIO bridge.
interface wb_gpio_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_gpio_bridge_in_sync.sv
// Per-pin input conditioning: SYNC_STAGES synchroniser, history flop and
// selectable edge detector producing a one-cycle event pulse.
module gpio_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic rise_sel,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  // Edge select only steers the compare, so flipping it never fakes an event
  assign pulse = rise_sel ? (level & ~hist_q) : (~level & hist_q);

endmodule

// File: rtl/wb_gpio_bridge.sv
// Wishbone-slave GPIO bridge: DOUT/OEB/DIN/IRQ registers, wait states and
// edge interrupts. Define WB_GPIO_LA_MIRROR_EN to drive la_data_out = {DIN, DOUT}.
module wb_gpio_bridge
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_IO      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00,
  parameter int          WAIT_STATES = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_gpio_bridge_if.slave       wbs,
  input  logic [NUM_IO-1:0]     io_in,
  output logic [NUM_IO-1:0]     io_out,
  output logic [NUM_IO-1:0]     io_oeb,
  output logic [2*NUM_IO-1:0]   la_data_out,
  output logic [2:0]            user_irq
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_t         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        off_q, rd_off;
  logic [NUM_IO-1:0] dat_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       rdat_q, rd_word;
  logic              hit, accept, wr;

  logic [NUM_IO-1:0] dout_q, oeb_q, irq_en_q, irq_stat_q, edge_q;
  logic [NUM_IO-1:0] din, evt, wm, clr;
  logic              irq_q;
  logic              unused_bits;

  assign hit    = (wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign accept = (state_q == S_IDLE) && wbs.wbs_cyc_i && wbs.wbs_stb_i && hit;
  assign wr     = (state_q == S_ACK) && we_q;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        cnt_d   = WS_LOAD;
      end
      S_WAIT: begin
        if (!wbs.wbs_cyc_i)    state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_ACK;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the read happens in the accept cycle, before capture
  assign rd_off = (state_q == S_IDLE) ? wbs.wbs_adr_i[7:2] : off_q;

  always_comb begin
    rd_word = '0;
    case (rd_off)
      OFF_DOUT:     rd_word = 32'(dout_q);
      OFF_OEB:      rd_word = 32'(oeb_q);
      OFF_DIN:      rd_word = 32'(din);
      OFF_IRQ_EN:   rd_word = 32'(irq_en_q);
      OFF_IRQ_STAT: rd_word = 32'(irq_stat_q);
      OFF_EDGE:     rd_word = 32'(edge_q);
      default:      rd_word = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_IO; i++) wm[i] = sel_q[i / 8];
  end

  assign clr = (wr && off_q == OFF_IRQ_STAT) ? (dat_q & wm) : '0;

  // NOTE: non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        off_q <= wbs.wbs_adr_i[7:2];
        dat_q <= wbs.wbs_dat_i[NUM_IO-1:0];
        we_q  <= wbs.wbs_we_i;
        sel_q <= wbs.wbs_sel_i;
      end
      rdat_q <= (state_d == S_ACK) ? rd_word : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dout_q     <= DOUT_RST[NUM_IO-1:0];
      oeb_q      <= OEB_RST[NUM_IO-1:0];
      irq_en_q   <= IRQ_EN_RST[NUM_IO-1:0];
      irq_stat_q <= IRQ_STAT_RST[NUM_IO-1:0];
      edge_q     <= EDGE_RST[NUM_IO-1:0];
      irq_q      <= 1'b0;
    end else begin
      if (wr && off_q == OFF_DOUT)   dout_q   <= (dout_q   & ~wm) | (dat_q & wm);
      if (wr && off_q == OFF_OEB)    oeb_q    <= (oeb_q    & ~wm) | (dat_q & wm);
      if (wr && off_q == OFF_IRQ_EN) irq_en_q <= (irq_en_q & ~wm) | (dat_q & wm);
      if (wr && off_q == OFF_EDGE)   edge_q   <= (edge_q   & ~wm) | (dat_q & wm);
      // A fresh event beats a simultaneous write-1-to-clear
      irq_stat_q <= (irq_stat_q & ~clr) | (evt & oeb_q);
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_in
    gpio_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .d        (io_in[i]),
      .rise_sel (edge_q[i]),
      .level    (din[i]),
      .pulse    (evt[i])
    );
  end

`ifdef WB_GPIO_LA_MIRROR_EN
  logic [2*NUM_IO-1:0] la_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) la_q <= '0;
    else          la_q <= {din, dout_q};
  end
  assign la_data_out = la_q;
`else
  assign la_data_out = '0;
`endif

  assign unused_bits   = ^{wbs.wbs_dat_i, sel_q};
  assign wbs.wbs_ack_o = (state_q == S_ACK);
  assign wbs.wbs_dat_o = rdat_q;
  assign io_out        = dout_q;
  assign io_oeb        = oeb_q;
  assign user_irq      = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_gpio_bridge.sv
// Directed bench for wb_gpio_bridge: one instance with 0 and one with 3 wait
// states share clock, reset and io_in; bus index 0 = WS0, 1 = WS3.
module tb_wb_gpio_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic [15:0] io_in;

  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic        ack_w [2];
  logic [31:0] dat_w [2];

  logic [15:0] io_out0, io_oeb0, io_out3, io_oeb3;
  logic [31:0] la0, la3;
  logic [2:0]  irq0, irq3;

  int checks   = 0;
  int failures = 0;

  wb_gpio_bridge_if bus0 ();
  wb_gpio_bridge_if bus3 ();

  assign bus0.wbs_cyc_i = cyc[0];
  assign bus0.wbs_stb_i = stb[0];
  assign bus0.wbs_we_i  = we[0];
  assign bus0.wbs_sel_i = sel[0];
  assign bus0.wbs_adr_i = adr[0];
  assign bus0.wbs_dat_i = wdat[0];
  assign ack_w[0]       = bus0.wbs_ack_o;
  assign dat_w[0]       = bus0.wbs_dat_o;

  assign bus3.wbs_cyc_i = cyc[1];
  assign bus3.wbs_stb_i = stb[1];
  assign bus3.wbs_we_i  = we[1];
  assign bus3.wbs_sel_i = sel[1];
  assign bus3.wbs_adr_i = adr[1];
  assign bus3.wbs_dat_i = wdat[1];
  assign ack_w[1]       = bus3.wbs_ack_o;
  assign dat_w[1]       = bus3.wbs_dat_o;

  wb_gpio_bridge #(.NUM_IO(16), .WAIT_STATES(0), .SYNC_STAGES(2)) dut0 (
    .wb_clk_i (clk), .wb_rst_i (rst), .wbs (bus0.slave),
    .io_in (io_in), .io_out (io_out0), .io_oeb (io_oeb0),
    .la_data_out (la0), .user_irq (irq0)
  );

  wb_gpio_bridge #(.NUM_IO(16), .WAIT_STATES(3), .SYNC_STAGES(2)) dut3 (
    .wb_clk_i (clk), .wb_rst_i (rst), .wbs (bus3.slave),
    .io_in (io_in), .io_out (io_out3), .io_oeb (io_oeb3),
    .la_data_out (la3), .user_irq (irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request goes out 1 time unit after an edge; ack is sampled 1 unit after
  // each following edge, so lat counts cycles from the stb-sampling edge.
  task automatic wb_access(input int d, input logic we_v, input logic [31:0] adr_v,
                           input logic [31:0] dat_v, input logic [3:0] sel_v,
                           input int max_cyc, output logic acked,
                           output logic [31:0] rdat, output int lat);
    acked = 1'b0;
    rdat  = '0;
    lat   = 0;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = we_v;
    adr[d] = adr_v; wdat[d] = dat_v; sel[d] = sel_v;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk); #1;
      if (ack_w[d] === 1'b1) begin
        acked = 1'b1;
        rdat  = dat_w[d];
        lat   = n;
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io_in = '0;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; sel[d] = '0; adr[d] = '0; wdat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (io_oeb0 !== 16'hFFFF) begin failures++; $display("FAIL reset_oeb got=%h exp=ffff", io_oeb0); end
    checks++;
    if (io_out0 !== 16'h0000) begin failures++; $display("FAIL reset_out got=%h exp=0000", io_out0); end
    checks++;
    if (ack_w[0] !== 1'b0 || dat_w[0] !== 32'h0) begin
      failures++; $display("FAIL reset_bus ack=%b dat=%h exp ack=0 dat=0", ack_w[0], dat_w[0]);
    end
    checks++;
    if (irq0 !== 3'b000 || la0 !== 32'h0) begin
      failures++; $display("FAIL reset_irq_la irq=%b la=%h exp 000/0", irq0, la0);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_write_sel();
    logic ok; logic [31:0] rd; int lat;
    wb_access(0, 1'b1, BASE + 32'h00, 32'h0000_A5A5, 4'b0001, 10, ok, rd, lat);
    checks++;
    if (!ok || lat != 1) begin failures++; $display("FAIL wr_dout_ack acked=%b lat=%0d exp 1/1", ok, lat); end
    @(posedge clk); #1;
    checks++;
    if (io_out0 !== 16'h00A5) begin failures++; $display("FAIL wr_dout_pad got=%h exp=00a5", io_out0); end
    wb_access(0, 1'b0, BASE + 32'h00, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (!ok || lat != 1 || rd !== 32'h0000_00A5) begin
      failures++; $display("FAIL rd_dout acked=%b lat=%0d got=%h exp=000000a5", ok, lat, rd);
    end
    wb_access(0, 1'b1, BASE + 32'h00, 32'hFFFF_3CFF, 4'b0010, 10, ok, rd, lat);
    wb_access(0, 1'b0, BASE + 32'h00, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h0000_3CA5) begin failures++; $display("FAIL wr_byte1 got=%h exp=00003ca5", rd); end
  endtask

  task automatic test_wait_states();
    logic ok; logic [31:0] rd; int lat; logic seen;
    wb_access(1, 1'b0, BASE + 32'h04, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (!ok || lat != 4 || rd !== 32'h0000_FFFF) begin
      failures++; $display("FAIL ws3_rd_oeb acked=%b lat=%0d got=%h exp 1/4/0000ffff", ok, lat, rd);
    end
    // Write DOUT but drop cyc two cycles into WAIT
    seen = 1'b0;
    @(posedge clk); #1;
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = BASE; wdat[1] = 32'hFFFF; sel[1] = 4'hF;
    repeat (2) begin @(posedge clk); #1; seen |= ack_w[1]; end
    cyc[1] = 0; stb[1] = 0; we[1] = 0;
    repeat (6) begin @(posedge clk); #1; seen |= ack_w[1]; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL ws3_cyc_drop_ack got=%b exp=0", seen); end
    wb_access(1, 1'b0, BASE + 32'h00, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (!ok || lat != 4 || rd !== 32'h0) begin
      failures++; $display("FAIL ws3_cyc_drop_nowrite acked=%b lat=%0d got=%h exp 1/4/0", ok, lat, rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic ok; logic [31:0] rd; int lat; logic seen;
    wb_access(1, 1'b1, BASE + 32'h04, 32'h0000_00FF, 4'hF, 10, ok, rd, lat);
    @(posedge clk); #1;
    checks++;
    if (io_oeb3 !== 16'h00FF) begin failures++; $display("FAIL mid_pre_oeb got=%h exp=00ff", io_oeb3); end
    @(posedge clk); #1;
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = BASE; wdat[1] = 32'h1234; sel[1] = 4'hF;
    @(posedge clk); #1;
    seen = ack_w[1];
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    seen |= ack_w[1];
    checks++;
    if (io_oeb3 !== 16'hFFFF || io_out3 !== 16'h0) begin
      failures++; $display("FAIL mid_reset_regs oeb=%h out=%h exp ffff/0000", io_oeb3, io_out3);
    end
    cyc[1] = 0; stb[1] = 0; we[1] = 0;
    @(negedge clk) rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= ack_w[1]; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_reset_ack got=%b exp=0", seen); end
    wb_access(1, 1'b0, BASE + 32'h00, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (!ok || rd !== 32'h0) begin failures++; $display("FAIL mid_reset_dout acked=%b got=%h exp 1/0", ok, rd); end
  endtask

  task automatic test_irq();
    logic ok; logic [31:0] rd; int lat;
    wb_access(0, 1'b1, BASE + 32'h0C, 32'h8, 4'hF, 10, ok, rd, lat);
    @(posedge clk); #1 io_in[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq0[0] !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq0[0]); end
    @(posedge clk); #1;
    checks++;
    if (irq0 !== 3'b001) begin failures++; $display("FAIL irq_rise got=%b exp=001", irq0); end
    checks++;
    if (irq3[0] !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b exp=0", irq3[0]); end
    wb_access(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h8) begin failures++; $display("FAIL irq_stat got=%h exp=00000008", rd); end
    wb_access(0, 1'b0, BASE + 32'h08, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h8) begin failures++; $display("FAIL din got=%h exp=00000008", rd); end
    wb_access(0, 1'b1, BASE + 32'h10, 32'h8, 4'hF, 10, ok, rd, lat);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq0[0] !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq0[0]); end
    // Switch bit 3 to falling edge while the pin sits high: no event expected
    wb_access(0, 1'b1, BASE + 32'h14, 32'hFFF7, 4'hF, 10, ok, rd, lat);
    repeat (3) @(posedge clk);
    wb_access(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL edge_switch_spurious got=%h exp=0", rd); end
    @(posedge clk); #1 io_in[3] = 1'b0;
    repeat (5) @(posedge clk);
    wb_access(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h8) begin failures++; $display("FAIL irq_fall got=%h exp=00000008", rd); end
    wb_access(0, 1'b1, BASE + 32'h10, 32'h8, 4'hF, 10, ok, rd, lat);
    wb_access(0, 1'b1, BASE + 32'h14, 32'hFFFF, 4'hF, 10, ok, rd, lat);
    // Pin 5 driven as output: its edges must not set status
    wb_access(0, 1'b1, BASE + 32'h04, 32'hFFDF, 4'hF, 10, ok, rd, lat);
    @(posedge clk); #1 io_in[5] = 1'b1;
    repeat (5) @(posedge clk);
    wb_access(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL irq_output_masked got=%h exp=0", rd); end
  endtask

  task automatic test_set_wins();
    logic ok; logic [31:0] rd; int lat;
    @(posedge clk); #1 io_in[3] = 1'b1;
    wb_access(0, 1'b1, BASE + 32'h10, 32'h8, 4'hF, 10, ok, rd, lat);
    wb_access(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h8) begin failures++; $display("FAIL set_wins got=%h exp=00000008", rd); end
    checks++;
    if (irq0[0] !== 1'b1) begin failures++; $display("FAIL set_wins_irq got=%b exp=1", irq0[0]); end
    wb_access(0, 1'b1, BASE + 32'h10, 32'h8, 4'hF, 10, ok, rd, lat);
  endtask

  task automatic test_miss_and_unmapped();
    logic ok; logic [31:0] rd; int lat;
    wb_access(0, 1'b1, 32'h3000_0100, 32'hFFFF, 4'hF, 20, ok, rd, lat);
    checks++;
    if (ok !== 1'b0 || dat_w[0] !== 32'h0) begin
      failures++; $display("FAIL miss acked=%b dat=%h exp 0/0", ok, dat_w[0]);
    end
    wb_access(0, 1'b1, BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF, 10, ok, rd, lat);
    wb_access(0, 1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, 10, ok, rd, lat);
    wb_access(0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (!ok || rd !== 32'h0) begin failures++; $display("FAIL unmapped_rd acked=%b got=%h exp 1/0", ok, rd); end
    wb_access(0, 1'b0, BASE + 32'h00, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h0 || io_out0 !== 16'h0) begin
      failures++; $display("FAIL miss_nowrite dout=%h pad=%h exp 0/0", rd, io_out0);
    end
    wb_access(0, 1'b0, BASE + 32'h08, 32'h0, 4'hF, 10, ok, rd, lat);
    checks++;
    if (rd !== 32'h0000_0028) begin failures++; $display("FAIL din_ro got=%h exp=00000028", rd); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] acks;
    logic [31:0] d0, d1, d2;
    logic [31:0] la_exp;
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = BASE + 32'h04; sel[0] = 4'hF;
    @(posedge clk); #1; acks[0] = ack_w[0]; d0 = dat_w[0];
    @(posedge clk); #1; acks[1] = ack_w[0]; d1 = dat_w[0];
    @(posedge clk); #1; acks[2] = ack_w[0]; d2 = dat_w[0];
    cyc[0] = 0; stb[0] = 0;
    checks++;
    if (acks !== 3'b101) begin failures++; $display("FAIL b2b_ack_pattern got=%b exp=101", acks); end
    checks++;
    if (d0 !== 32'hFFDF || d1 !== 32'h0 || d2 !== 32'hFFDF) begin
      failures++; $display("FAIL b2b_data got=%h/%h/%h exp=0000ffdf/0/0000ffdf", d0, d1, d2);
    end
`ifdef WB_GPIO_LA_MIRROR_EN
    la_exp = {16'h0028, 16'h0000};
`else
    la_exp = 32'h0;
`endif
    checks++;
    if (la0 !== la_exp) begin failures++; $display("FAIL la_mirror got=%h exp=%h", la0, la_exp); end
  endtask

  initial begin
    test_reset();
    test_write_sel();
    test_wait_states();
    test_reset_mid_wait();
    test_irq();
    test_set_wins();
    test_miss_and_unmapped();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_gpio_bridge.md
Name: wb_gpio_bridge

Overview:
- Parametrised Wishbone-slave GPIO bridge between the management SoC Wishbone bus and NUM_IO user I/O pads.
- Adds to the plain pass-through wrapper generation:
  - memory-mapped output, output-enable, input and interrupt registers;
  - synchronised inputs;
  - configurable wait states;
  - edge-triggered interrupts on user_irq.
- Instantiated inside user_project_wrapper alongside user project logic.

Parameters:
- NUM_IO, 16, number of GPIO channels, 1..32; register bits above NUM_IO-1 read 0.
- BASE_ADDR, 32'h3000_0000, window base address.
- ADDR_MASK, 32'hFFFF_FF00, address bits compared against BASE_ADDR.
- WAIT_STATES, 0, extra cycles between request accept and ack, 0..15.
- SYNC_STAGES, 2, input synchroniser flops, 2..4.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_in  in  NUM_IO  pad inputs, asynchronous.
- io_out  out  NUM_IO  pad outputs = DOUT register.
- io_oeb  out  NUM_IO  active-low output enable = OEB register.
- la_data_out  out  2*NUM_IO  logic-analyser mirror (see Optional Feature).
- user_irq  out  3  [0] GPIO interrupt; [2:1] tied 0.

Behaviour:
- Address hit: (wbs_adr_i & ADDR_MASK) == BASE_ADDR.
- Register offsets, word-aligned (wbs_adr_i[7:2]):
  - 0x00 DOUT, rw.
  - 0x04 OEB, rw; reset all-ones, i.e. inputs.
  - 0x08 DIN, ro; synchronised io_in.
  - 0x0C IRQ_EN, rw.
  - 0x10 IRQ_STAT, read / write-1-to-clear.
  - 0x14 EDGE, rw; 1 = rising, 0 = falling.
  - Other offsets inside the window: ack, read 0, write ignored.
- Writes honour wbs_sel_i per byte. Writes to DIN are ignored.
- Handshake FSM states IDLE, WAIT, ACK:
  - IDLE -> WAIT when cyc&stb&hit and WAIT_STATES>0.
  - IDLE -> ACK directly when WAIT_STATES==0.
  - WAIT counts WAIT_STATES cycles, then -> ACK.
  - ACK asserts wbs_ack_o for exactly one cycle, performs the write on that edge, then -> IDLE unconditionally.
  - Latency from stb sample to ack = 1+WAIT_STATES cycles.
  - The IDLE cycle after ACK enforces one dead cycle between back-to-back accesses.
- Address, data, we and sel are captured at accept. Bus changes during WAIT are ignored.
- If cyc drops during WAIT: return to IDLE, no ack, no write.
- Miss (no hit): never ack; wbs_dat_o = 0.
- wbs_dat_o:
  - Valid only while ack is high.
  - Registered, updated in the same transition that raises ack.
  - 0 otherwise.
- Input path:
  - SYNC_STAGES flop chain, then one history flop for edge detection.
  - DIN latency = SYNC_STAGES cycles.
- IRQ_STAT[i] set on the selected edge of synchronised io_in[i] when OEB[i]=1. Bits with OEB[i]=0 never set.
- Same cycle set and W1C clear: set wins.
- user_irq[0] = |(IRQ_STAT & IRQ_EN), registered, one cycle after the status update.
- Changing EDGE takes effect the next cycle. It does not generate a spurious event because the history flop is unaffected.
- Reset values (asynchronous, including mid-transaction):
  - FSM to IDLE; wbs_ack_o=0; wbs_dat_o=0.
  - DOUT=0, OEB=all-ones, IRQ_EN=0, IRQ_STAT=0, EDGE=all-ones.
  - Synchroniser and history flops = 0.
  - user_irq=0; la_data_out=0.
  - A transaction interrupted by reset is never acked.

Optional Feature:
- WB_GPIO_LA_MIRROR_EN defined: la_data_out = {DIN, DOUT}, registered, one cycle behind the registers.
- Undefined: la_data_out tied 0; no mirror flops instantiated.

Decomposition:
- Package wb_gpio_pkg:
  - register offset constants;
  - FSM state typedef (IDLE/WAIT/ACK);
  - reset-value constants.
- Sub-module gpio_in_sync, one instance per bit (generate):
  - SYNC_STAGES synchroniser, history flop, edge select;
  - outputs the synced level and a one-cycle event pulse.

Test Plan:
- Reset mid-WAIT (WAIT_STATES=3), asserted while the FSM is in WAIT -> no ack; registers return to reset values; io_oeb=16'hFFFF.
- Write DOUT=32'h0000_A5A5 with sel=4'b0001, WAIT_STATES=0 -> ack 1 cycle after stb; io_out=16'h00A5; readback 32'h0000_00A5.
- WAIT_STATES=3, read OEB -> ack on cycle 4; data 32'h0000_FFFF. Drop cyc on cycle 2 instead -> no ack; FSM returns to IDLE.
- OEB=all-ones, EDGE[3]=1, IRQ_EN[3]=1, io_in[3] 0->1 -> IRQ_STAT=32'h8 and user_irq[0]=1 at SYNC_STAGES+2 cycles. W1C 32'h8 -> user_irq[0]=0.
- W1C on bit 3 in the same cycle as a new rising edge on io_in[3] -> IRQ_STAT[3] stays 1.
- Access 0x3000_0100 (miss) -> no ack within 20 cycles. Access offset 0x3C -> ack, read 0.
